fp_mult_pipe: RTL and testbench
===============================

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (bias = 2^(EXP_W-1)-1).
REQ-002 Parameter MAN_W, default 23, stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  opd1/opd2 carry a valid operand pair.
REQ-006 in_ready  out  1  block accepts a pair this cycle.
REQ-007 opd1, opd2  in  W each  IEEE-754-style operands (sign, exponent, mantissa).
REQ-008 out_valid  out  1  res and flags hold a valid result.
REQ-009 out_ready  in  1  consumer accepts the result this cycle.
REQ-010 res  out  W  product.
REQ-011 exp_overflow, nan, zero  out  1 each  result flags, qualified by out_valid.

Function
REQ-012 Pipeline is exactly 3 stages: S1 unpack/classify + exponent sum; S2 (MAN_W+1)x(MAN_W+1) significand multiply; S3 normalise, round, pack.
REQ-013 Latency is 3 cycles from input handshake (in_valid & in_ready) to out_valid with no back-pressure; throughput 1 result/cycle.
REQ-014 Global advance en = ~out_valid | out_ready; in_ready = en; when en=0 every stage register (data and valid) holds.
REQ-015 Bubbles propagate as valid=0; stage data registers load only when en=1.
REQ-016 res and flags stay stable while out_valid=1 and out_ready=0.
REQ-017 Result sign = sign(opd1) XOR sign(opd2) for all non-NaN results.
REQ-018 Subnormal operands are treated as zero (flush-to-zero); subnormal results flush to signed zero.
REQ-019 Either operand NaN, or inf x zero -> res = canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0), nan=1, other flags 0.
REQ-020 Inf x nonzero finite, or inf x inf -> signed infinity, all flags 0.
REQ-021 Zero x finite -> signed zero, zero=1.
REQ-022 Finite rounding is round-to-nearest-even using guard, round and sticky bits of the 2(MAN_W+1)-bit product.
REQ-023 Product in [2,4): shift right 1, exponent +1, before rounding; mantissa carry-out on rounding: exponent +1 again.
REQ-024 Biased result exponent >= all-ones after rounding, with finite operands -> signed infinity, exp_overflow=1.
REQ-025 Biased result exponent <= 0 -> signed zero, zero=1, exp_overflow=0.
REQ-026 Exponent arithmetic uses EXP_W+2-bit signed intermediates; no wrap-around permitted.
REQ-027 At most one of nan, exp_overflow, zero is 1 in any valid result.

Reset
REQ-028 While rst=1 at a clock edge: all stage valids cleared, out_valid=0, res=0, flags=0.
REQ-029 in_ready is 1 in the first cycle after reset release.
REQ-030 Reset mid-operation discards all in-flight pairs; no result for them ever appears.
REQ-031 rst has priority over en.

Structure
REQ-032 Package fp_pkg holds EXP_W/MAN_W defaults, the operand-class enum (ZERO, NORM, INF, NAN), the unpacked-operand struct, and a canonical-qNaN constant function.
REQ-033 Sub-module fp_round (normalise + round-nearest-even + pack, combinational) is instantiated in S3.
REQ-034 No latches; all stage registers in one always_ff per stage.

Verification
REQ-035 0x3FC00000 x 0x40000000, out_ready=1 -> 3 cycles later res=0x40400000, flags 000.
REQ-036 0x3F800001 x 0x3F800001 -> res=0x3F800002 (rounded down, sticky only); 0x7F7FFFFF x 0x40000000 -> res=0x7F800000, exp_overflow=1.
REQ-037 0x7F800000 x 0x00000000 -> res=0x7FC00000, nan=1; 0x00800000 x 0x00800000 -> res=0x00000000, zero=1; 0x80000000 x 0x3F800000 -> res=0x80000000, zero=1.
REQ-038 Stream 5 pairs with out_ready=0 from cycle 2 -> in_ready falls once out_valid=1, res held stable; release out_ready -> all 5 results in order, none lost or duplicated.
REQ-039 Assert rst for 1 cycle with 3 pairs in flight -> out_valid=0 next cycle, no stale results emerge; next pair after release returns in 3 cycles.
REQ-040 Random bench with EXP_W=5, MAN_W=10 and default params, compared bit-exact against a file-driven reference model with FTZ and RNE.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and helpers for the pipelined floating-point multiplier
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  typedef struct packed {
    logic      sign;
    fp_class_e cls;
  } fp_opd_t;

  // Subnormal encodings classify as ZERO, which gives flush-to-zero on input.
  function automatic fp_class_e classify(input logic exp_ones, input logic exp_zero,
                                         input logic man_nz);
    if (exp_ones) return man_nz ? NAN : INF;
    if (exp_zero) return ZERO;
    return NORM;
  endfunction

  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return (ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round.sv
// rtl/fp_round.sv - normalise, round-nearest-even and pack one product (combinational)
module fp_round
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                    sign,
  input  fp_class_e               cls,
  input  logic signed [EXP_W+1:0] exp_sum,
  input  logic [2*MAN_W+1:0]      prod,
  output logic [EXP_W+MAN_W:0]    res,
  output logic                    exp_overflow,
  output logic                    nan,
  output logic                    zero
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int XW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [XW-1:0] EXP_MAX = XW'(EMAX);
  localparam logic [W-1:0]         QNAN    = W'(qnan_bits(EXP_W, MAN_W));

  logic                 hi, g, r, s, round_up, carry;
  logic [MAN_W-1:0]     frac, frac_r;
  logic signed [XW-1:0] exp_n, exp_r;

  // A product in [2,4) has its leading one one place higher: take every field one bit up.
  always_comb begin
    hi = prod[PW-1];
    if (hi) begin
      frac = prod[PW-2 -: MAN_W];
      g    = prod[MAN_W];
      r    = prod[MAN_W-1];
      s    = |prod[MAN_W-2:0];
    end else begin
      frac = prod[PW-3 -: MAN_W];
      g    = prod[MAN_W-1];
      r    = prod[MAN_W-2];
      s    = |prod[MAN_W-3:0];
    end
    round_up        = g & (r | s | frac[0]);
    {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    exp_n           = exp_sum + XW'(hi);
    exp_r           = exp_n + XW'(carry);
  end

  always_comb begin
    res          = '0;
    exp_overflow = 1'b0;
    nan          = 1'b0;
    zero         = 1'b0;
    case (cls)
      NAN: begin
        res = QNAN;
        nan = 1'b1;
      end
      INF:  res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ZERO: begin
        res  = {sign, {(W-1){1'b0}}};
        zero = 1'b1;
      end
      default: begin
        if (exp_r >= EXP_MAX) begin
          res          = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          exp_overflow = 1'b1;
        end else if (exp_r[XW-1] || exp_r == '0) begin
          res  = {sign, {(W-1){1'b0}}};
          zero = 1'b1;
        end else begin
          res = {sign, exp_r[EXP_W-1:0], frac_r};
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - three-stage floating-point multiplier with valid/ready handshake
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] opd1,
  input  logic [EXP_W+MAN_W:0] opd2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] res,
  output logic                 exp_overflow,
  output logic                 nan,
  output logic                 zero
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  fp_opd_t              opa, opb;
  fp_class_e            cls_c;
  logic signed [XW-1:0] ea, eb;

  always_comb begin
    opa.sign = opd1[W-1];
    opa.cls  = classify(&opd1[W-2 -: EXP_W], ~|opd1[W-2 -: EXP_W], |opd1[MAN_W-1:0]);
    opb.sign = opd2[W-1];
    opb.cls  = classify(&opd2[W-2 -: EXP_W], ~|opd2[W-2 -: EXP_W], |opd2[MAN_W-1:0]);
    ea       = {2'b00, opd1[W-2 -: EXP_W]};
    eb       = {2'b00, opd2[W-2 -: EXP_W]};
    if (opa.cls == NAN || opb.cls == NAN ||
        (opa.cls == INF && opb.cls == ZERO) || (opa.cls == ZERO && opb.cls == INF))
      cls_c = NAN;
    else if (opa.cls == INF || opb.cls == INF)
      cls_c = INF;
    else if (opa.cls == ZERO || opb.cls == ZERO)
      cls_c = ZERO;
    else
      cls_c = NORM;
  end

  logic                 s1_valid, s1_sign;
  fp_class_e            s1_cls;
  logic signed [XW-1:0] s1_exp;
  logic [SW-1:0]        s1_sig_a, s1_sig_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= opa.sign ^ opb.sign;
      s1_cls   <= cls_c;
      s1_exp   <= ea + eb - BIAS;
      s1_sig_a <= {1'b1, opd1[MAN_W-1:0]};
      s1_sig_b <= {1'b1, opd2[MAN_W-1:0]};
    end
  end

  logic                 s2_valid, s2_sign;
  fp_class_e            s2_cls;
  logic signed [XW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_cls   <= s1_cls;
      s2_exp   <= s1_exp;
      s2_prod  <= PW'(s1_sig_a) * PW'(s1_sig_b);
    end
  end

  logic [W-1:0] rnd_res;
  logic         rnd_ovf, rnd_nan, rnd_zero;

  fp_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign         (s2_sign),
    .cls          (s2_cls),
    .exp_sum      (s2_exp),
    .prod         (s2_prod),
    .res          (rnd_res),
    .exp_overflow (rnd_ovf),
    .nan          (rnd_nan),
    .zero         (rnd_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      res          <= '0;
      exp_overflow <= 1'b0;
      nan          <= 1'b0;
      zero         <= 1'b0;
    end else if (en) begin
      out_valid    <= s2_valid;
      res          <= rnd_res;
      exp_overflow <= rnd_ovf;
      nan          <= rnd_nan;
      zero         <= rnd_zero;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - self-checking bench for fp_mult_pipe (binary32 and 5/10 formats)
module tb_fp_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [31:0] opd1, opd2, res;
  logic        in_ready, out_valid, exp_overflow, nan, zero;
  logic [15:0] hopd1, hopd2, hres;
  logic        hin_ready, hout_valid, hexp_overflow, hnan, hzero;

  fp_mult_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opd1(opd1), .opd2(opd2), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .exp_overflow(exp_overflow), .nan(nan), .zero(zero)
  );

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(hin_ready),
    .opd1(hopd1), .opd2(hopd2), .out_valid(hout_valid), .out_ready(out_ready),
    .res(hres), .exp_overflow(hexp_overflow), .nan(hnan), .zero(hzero)
  );

  int        n_pass = 0, n_total = 0, n_out = 0;
  bit [34:0] exp_q[$];
  bit [18:0] exp_hq[$];
  bit        obs_valid, obs_in_ready, last_in_fire, hold_pending;
  bit [34:0] obs_val, held_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: exact integer product, then quotient/remainder rounding to nearest-even.
  function automatic bit [34:0] ref_mul(input int ew, input int mw, input bit [31:0] a,
                                        input bit [31:0] b);
    longint one, emax, bias, mmask, av, bv, ea, eb, ma, mb, sbit, infv, p, q, rem, half, e;
    bit an, bn, ai, bi, az, bz;
    int sh;
    one  = 1;
    emax = (one << ew) - 1;
    bias = (one << (ew - 1)) - 1;
    mmask = (one << mw) - 1;
    av = longint'(a);
    bv = longint'(b);
    ea = (av >> mw) & emax;
    eb = (bv >> mw) & emax;
    ma = av & mmask;
    mb = bv & mmask;
    sbit = (((av >> (ew + mw)) ^ (bv >> (ew + mw))) & 1) << (ew + mw);
    infv = sbit | (emax << mw);
    an = (ea == emax) && (ma != 0);  ai = (ea == emax) && (ma == 0);  az = (ea == 0);
    bn = (eb == emax) && (mb != 0);  bi = (eb == emax) && (mb == 0);  bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {3'b010, 32'((emax << mw) | (one << (mw - 1)))};
    if (ai || bi) return {3'b000, 32'(infv)};
    if (az || bz) return {3'b001, 32'(sbit)};
    p  = ((one << mw) | ma) * ((one << mw) | mb);
    e  = ea + eb - bias;
    sh = mw;
    if (p >= (one << (2 * mw + 1))) begin e++; sh++; end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = one << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == (one << (mw + 1))) begin q = q >> 1; e++; end
    if (e >= emax) return {3'b100, 32'(infv)};
    if (e <= 0) return {3'b001, 32'(sbit)};
    return {3'b000, 32'(sbit | (e << mw) | (q & mmask))};
  endfunction

  function automatic bit [31:0] genop(input int ew, input int mw);
    int        emax, bias, e;
    bit [31:0] man, sgn;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    man  = $urandom & ((32'd1 << mw) - 32'd1);
    sgn  = 32'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0: e = int'($urandom_range(0, emax));
      1: e = bias - 6 + int'($urandom_range(0, 12));
      2: begin
        e = ($urandom_range(0, 1) != 0) ? 0 : emax;
        if ($urandom_range(0, 1) != 0) man = 32'd0;
      end
      3: e = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 4)) : emax - int'($urandom_range(1, 4));
      default: begin
        e   = bias + int'($urandom_range(0, 1));
        man = man & ((32'd1 << (mw - 1)) | 32'd3);
      end
    endcase
    return (sgn << (ew + mw)) | (32'(e) << mw) | man;
  endfunction

  task automatic sample();
    bit [34:0] cur, r;
    bit [18:0] hcur;
    cur  = {exp_overflow, nan, zero, res};
    hcur = {hexp_overflow, hnan, hzero, hres};
    obs_valid    = out_valid;
    obs_val      = cur;
    obs_in_ready = in_ready;
    if (hold_pending) check("hold_stable", 64'({out_valid, cur}), 64'({1'b1, held_val}));
    hold_pending = out_valid && !out_ready && !rst;
    held_val     = cur;
    if (out_valid && out_ready) begin
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("res_fp32", 64'(cur), 64'(exp_q.pop_front()));
      n_out++;
    end
    if (hout_valid && out_ready) begin
      check("out_expected_h", 64'(exp_hq.size() != 0), 64'd1);
      if (exp_hq.size() != 0) check("res_fp16", 64'(hcur), 64'(exp_hq.pop_front()));
    end
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) exp_q.push_back(ref_mul(8, 23, opd1, opd2));
    if (in_valid && hin_ready) begin
      r = ref_mul(5, 10, {16'h0, hopd1}, {16'h0, hopd2});
      exp_hq.push_back({r[34:32], r[15:0]});
    end
    if (rst) begin
      exp_q.delete();
      exp_hq.delete();
    end
  endtask

  task automatic drive(input bit v, input bit [31:0] a, input bit [31:0] b, input bit ordy);
    in_valid  = v;
    opd1      = a;
    opd2      = b;
    out_ready = ordy;
    hopd1     = 16'(genop(5, 10));
    hopd2     = 16'(genop(5, 10));
    #1;
    sample();
    @(negedge clk);
  endtask

  task automatic expect_one(input string tag, input bit [31:0] a, input bit [31:0] b,
                            input bit [34:0] expv);
    int lat;
    lat = 0;
    drive(1'b1, a, b, 1'b1);
    check({tag, "_accept"}, 64'(last_in_fire), 64'd1);
    do begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      lat++;
    end while (!obs_valid && lat < 10);
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check(tag, 64'(obs_val), 64'(expv));
  endtask

  bit [31:0] dir_a [12] = '{32'h3FC00000, 32'h3F800001, 32'h7F7FFFFF, 32'h7F800000,
                            32'h00800000, 32'h80000000, 32'h3F800001, 32'h3F800003,
                            32'h3FC00000, 32'h7F800000, 32'hFFC00001, 32'h00000001};
  bit [31:0] dir_b [12] = '{32'h40000000, 32'h3F800001, 32'h40000000, 32'h00000000,
                            32'h00800000, 32'h3F800000, 32'h3FC00000, 32'h3FC00000,
                            32'h3FC00000, 32'hC0000000, 32'h3F800000, 32'h7F000000};
  bit [34:0] dir_r [12] = '{35'h0_40400000, 35'h0_3F800002, 35'h4_7F800000, 35'h2_7FC00000,
                            35'h1_00000000, 35'h1_80000000, 35'h0_3FC00002, 35'h0_3FC00004,
                            35'h0_40100000, 35'h0_FF800000, 35'h2_7FC00000, 35'h1_00000000};

  initial begin
    int        acc, c, start;
    bit        ordy;
    bit [31:0] sa [5], sb [5];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opd1 = '0; opd2 = '0; hopd1 = '0; hopd2 = '0;
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_flags", 64'({exp_overflow, nan, zero}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1);

    for (int i = 0; i < 12; i++)
      expect_one($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_r[i]);

    // Back-pressure: consumer stalls from cycle 2 to 7, then drains.
    for (int i = 0; i < 5; i++) begin
      sa[i] = genop(8, 23);
      sb[i] = genop(8, 23);
    end
    acc = 0; c = 0; start = n_out;
    while (acc < 5 && c < 40) begin
      ordy = (c < 2) || (c >= 8);
      drive(1'b1, sa[acc], sb[acc], ordy);
      if (c >= 3 && c <= 7) check("bp_in_ready_low", 64'(obs_in_ready), 64'd0);
      if (last_in_fire) acc++;
      c++;
    end
    check("bp_accepted", 64'(acc), 64'd5);
    c = 0;
    while (exp_q.size() != 0 && c < 20) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      c++;
    end
    check("bp_result_count", 64'(n_out - start), 64'd5);

    // Reset with three pairs in flight.
    for (int i = 0; i < 3; i++) drive(1'b1, genop(8, 23), genop(8, 23), 1'b1);
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_res", 64'(res), 64'd0);
    start = n_out;
    repeat (6) drive(1'b0, 32'd0, 32'd0, 1'b1);
    check("midrst_no_stale", 64'(n_out - start), 64'd0);
    expect_one("after_rst", 32'h3FC00000, 32'h3FC00000, 35'h0_40100000);

    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, genop(8, 23), genop(8, 23), $urandom_range(0, 3) != 0);
    c = 0;
    while ((exp_q.size() != 0 || exp_hq.size() != 0) && c < 40) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      c++;
    end
    check("final_queue", 64'(exp_q.size()), 64'd0);
    check("final_queue_h", 64'(exp_hq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
